// File: rtl/mode_pkg.sv
// Shared definitions for the mode-sequencing stage and its done-pulse monitor:
// batch FSM encoding and the default period/batch limits.
package mode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REQ     = 2'd2
  } batch_state_e;

  localparam int unsigned DEF_BATCH_LEN  = 4;
  localparam int unsigned DEF_PERIOD_MIN = 12;
  localparam int unsigned DEF_PERIOD_MAX = 14;
  localparam int unsigned DEF_CW         = 8;

endpackage

// File: rtl/mode_interval_timer.sv
// Measures the spacing between done pulses, checks it against the legal window
// and reports the error / timeout events to the parent.
module mode_interval_timer
  import mode_pkg::*;
#(
  parameter int unsigned CW         = DEF_CW,
  parameter int unsigned PERIOD_MIN = DEF_PERIOD_MIN,
  parameter int unsigned PERIOD_MAX = DEF_PERIOD_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          done_i,
  output logic [CW-1:0] last_interval_o,
  output logic          err_pulse_o,
  output logic          err_evt_o,
  output logic          timeout_evt_o
);

  localparam logic [CW-1:0] TIMEOUT    = '1;
  localparam logic [CW-1:0] TIMEOUT_M1 = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] MIN_L      = CW'(PERIOD_MIN);
  localparam logic [CW-1:0] MAX_L      = CW'(PERIOD_MAX);

  logic [CW-1:0] icnt_q, icnt_d;
  logic [CW-1:0] last_q, last_d;
  logic [CW-1:0] interval;
  logic          armed_q, armed_d;
  logic          err_q;
  logic          measure;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    interval      = (icnt_q == TIMEOUT) ? TIMEOUT : icnt_q + ONE;
    measure       = done_i & armed_q;
    err_evt_o     = measure & ((interval < MIN_L) | (interval > MAX_L));
    // Fires only on the step into saturation, so a clr while idle stays cleared.
    timeout_evt_o = ~done_i & armed_q & (icnt_q == TIMEOUT_M1);
    armed_d       = armed_q | done_i;
    last_d        = measure ? interval : last_q;
    icnt_d        = icnt_q;
    if (done_i)                              icnt_d = '0;
    else if (armed_q && (icnt_q != TIMEOUT)) icnt_d = icnt_q + ONE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; all of them are reset because each one is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_q  <= '0;
      armed_q <= 1'b0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      icnt_q  <= icnt_d;
      armed_q <= armed_d;
      last_q  <= last_d;
      err_q   <= err_evt_o;
    end
  end

  assign last_interval_o = last_q;
  assign err_pulse_o     = err_q;

endmodule

// File: rtl/mode_done_monitor.sv
// Consumes the mode FSM's done pulse: interval checking, error/timeout flags and
// grouping of pulses into batches offered over a req/ack handshake.
module mode_done_monitor
  import mode_pkg::*;
#(
  parameter int unsigned BATCH_LEN  = DEF_BATCH_LEN,
  parameter int unsigned PERIOD_MIN = DEF_PERIOD_MIN,
  parameter int unsigned PERIOD_MAX = DEF_PERIOD_MAX,
  parameter int unsigned CW         = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          done_in,
  input  logic          batch_ack,
  input  logic          clr,
  output logic          batch_req,
  output logic [CW-1:0] last_interval,
  output logic          err_pulse,
  output logic [7:0]    err_cnt,
  output logic          overrun,
  output logic          timeout
);

  localparam logic [3:0] BL = 4'(BATCH_LEN);

  batch_state_e state_q, state_d;
  logic [3:0]   pend_q, pend_d, pend_inc;
  logic [7:0]   err_cnt_q, err_cnt_d;
  logic         batch_req_q;
  logic         overrun_q, overrun_d, overrun_evt;
  logic         timeout_q, timeout_d;
  logic         err_evt, timeout_evt;

  mode_interval_timer #(
    .CW         (CW),
    .PERIOD_MIN (PERIOD_MIN),
    .PERIOD_MAX (PERIOD_MAX)
  ) u_timer (
    .clk             (clk),
    .rst_n           (rst_n),
    .done_i          (done_in),
    .last_interval_o (last_interval),
    .err_pulse_o     (err_pulse),
    .err_evt_o       (err_evt),
    .timeout_evt_o   (timeout_evt)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    overrun_evt = 1'b0;
    pend_inc    = pend_q + 4'd1;
    case (state_q)
      ST_IDLE: begin
        if (done_in) begin
          if (BL == 4'd1) begin
            state_d = ST_REQ;
            pend_d  = 4'd0;
          end else begin
            state_d = ST_COLLECT;
            pend_d  = 4'd1;
          end
        end
      end
      ST_COLLECT: begin
        // A batch that filled up while the previous one waited goes out at once.
        if (pend_q == BL) begin
          state_d = ST_REQ;
          pend_d  = done_in ? 4'd1 : 4'd0;
        end else if (done_in) begin
          if (pend_inc == BL) begin
            state_d = ST_REQ;
            pend_d  = 4'd0;
          end else begin
            pend_d  = pend_inc;
          end
        end
      end
      ST_REQ: begin
        if (done_in && (pend_q != BL)) begin
          pend_d      = pend_inc;
          overrun_evt = (pend_inc == BL);
        end
        if (batch_ack) state_d = ST_COLLECT;
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 4'd0;
      end
    endcase
  end

  // clr wins over the stored value, but an event in the same cycle still lands.
  always_comb begin
    err_cnt_d = clr ? 8'd0 : err_cnt_q;
    if (err_evt && (err_cnt_d != 8'hFF)) err_cnt_d = err_cnt_d + 8'd1;
    overrun_d = (overrun_q & ~clr) | overrun_evt;
    timeout_d = (timeout_q & ~clr) | timeout_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 4'd0;
      batch_req_q <= 1'b0;
      err_cnt_q   <= 8'd0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      batch_req_q <= (state_d == ST_REQ);
      err_cnt_q   <= err_cnt_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign batch_req = batch_req_q;
  assign err_cnt   = err_cnt_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mode_done_monitor.sv
// Directed-plus-random bench for mode_done_monitor against a timestamp-based
// reference model of the interval, error and batch rules.
module tb_mode_done_monitor;

  localparam int BL   = 4;
  localparam int PMIN = 12;
  localparam int PMAX = 14;
  localparam int TMO  = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       done_in = 1'b0;
  logic       batch_ack = 1'b0;
  logic       clr = 1'b0;
  logic       batch_req, err_pulse, overrun, timeout;
  logic [7:0] last_interval, err_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: time stamps of done pulses plus batch bookkeeping.
  int         cyc = 0;
  int         last_done = 0;
  int         m_pend = 0;
  int         req_age = 0;
  int         ack_delay = 2;
  logic       armed = 1'b0;
  logic       m_req = 1'b0;
  logic       m_errp = 1'b0;
  logic       m_timeout = 1'b0;
  logic       m_overrun = 1'b0;
  logic [7:0] m_last = 8'd0;
  logic [7:0] m_errcnt = 8'd0;

  always #5 clk = ~clk;

  mode_done_monitor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .done_in       (done_in),
    .batch_ack     (batch_ack),
    .clr           (clr),
    .batch_req     (batch_req),
    .last_interval (last_interval),
    .err_pulse     (err_pulse),
    .err_cnt       (err_cnt),
    .overrun       (overrun),
    .timeout       (timeout)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk1("batch_req", batch_req, m_req);
    chk8("last_interval", last_interval, m_last);
    chk1("err_pulse", err_pulse, m_errp);
    chk8("err_cnt", err_cnt, m_errcnt);
    chk1("overrun", overrun, m_overrun);
    chk1("timeout", timeout, m_timeout);
  endtask

  task automatic model_reset();
    armed = 1'b0; m_req = 1'b0; m_errp = 1'b0; m_timeout = 1'b0; m_overrun = 1'b0;
    m_last = 8'd0; m_errcnt = 8'd0; m_pend = 0; req_age = 0;
  endtask

  task automatic model_edge(input logic d, input logic a, input logic c);
    int iv;
    cyc++;
    m_errp = 1'b0;
    if (c) begin
      m_errcnt = 8'd0; m_timeout = 1'b0; m_overrun = 1'b0;
    end
    if (d) begin
      if (armed) begin
        iv = cyc - last_done;
        if (iv > TMO) iv = TMO;
        m_last = 8'(iv);
        m_errp = (iv < PMIN) || (iv > PMAX);
        if (m_errp && m_errcnt != 8'd255) m_errcnt = m_errcnt + 8'd1;
      end
      armed = 1'b1;
      last_done = cyc;
    end else if (armed && (cyc - last_done == TMO)) begin
      m_timeout = 1'b1;
    end
    if (!m_req) begin
      if (m_pend == BL) begin
        m_req = 1'b1;
        m_pend = d ? 1 : 0;
      end else if (d) begin
        m_pend++;
        if (m_pend == BL) begin
          m_req = 1'b1;
          m_pend = 0;
        end
      end
    end else begin
      if (d && m_pend < BL) begin
        m_pend++;
        if (m_pend == BL) m_overrun = 1'b1;
      end
      if (a) m_req = 1'b0;
    end
    req_age = m_req ? req_age + 1 : 0;
  endtask

  // One clock: drive, let the edge happen, update the model, compare.
  task automatic cycle(input logic d, input logic c);
    logic a;
    a = (ack_delay >= 0) && m_req && (req_age >= ack_delay);
    done_in = d; batch_ack = a; clr = c;
    @(posedge clk);
    model_edge(d, a, c);
    #1;
    done_in = 1'b0; batch_ack = 1'b0; clr = 1'b0;
    check_all();
  endtask

  task automatic pulse_after(input int gap, input logic c);
    for (int i = 1; i < gap; i++) cycle(1'b0, 1'b0);
    cycle(1'b1, c);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: steady 13-cycle pulses, ack two cycles after req
    ack_delay = 2;
    pulse_after(5, 1'b0);
    pulse_after(13, 1'b0);
    pulse_after(13, 1'b0);
    chk1("p1_req_before4", batch_req, 1'b0);
    pulse_after(13, 1'b0);
    chk1("p1_req_after4", batch_req, 1'b1);
    for (int i = 0; i < 7; i++) pulse_after($urandom_range(PMIN, PMAX), 1'b0);
    pulse_after(13, 1'b0);
    chk8("p1_last", last_interval, 8'd13);
    chk8("p1_errcnt", err_cnt, 8'd0);

    // 2: 13, 10, 20
    pulse_after(13, 1'b0);
    chk1("p2_ok", err_pulse, 1'b0);
    pulse_after(10, 1'b0);
    chk1("p2_short", err_pulse, 1'b1);
    pulse_after(20, 1'b0);
    chk1("p2_long", err_pulse, 1'b1);
    chk8("p2_last", last_interval, 8'd20);
    chk8("p2_errcnt", err_cnt, 8'd2);
    cycle(1'b0, 1'b0);
    chk1("p2_pulse_end", err_pulse, 1'b0);

    // 3: no ack while a second batch fills -> overrun, backlog re-request
    ack_delay = -1;
    for (int i = 0; i < 2 * BL && !m_req; i++) pulse_after(13, 1'b0);
    chk1("p3_req", batch_req, 1'b1);
    for (int i = 0; i < 2 * BL && m_pend < BL - 1; i++) pulse_after(13, 1'b0);
    chk1("p3_no_overrun", overrun, 1'b0);
    pulse_after(13, 1'b0);
    chk1("p3_overrun", overrun, 1'b1);
    pulse_after(13, 1'b0);
    ack_delay = 0;
    cycle(1'b0, 1'b0);
    chk1("p3_ack_low", batch_req, 1'b0);
    cycle(1'b0, 1'b0);
    chk1("p3_rereq", batch_req, 1'b1);
    cycle(1'b0, 1'b0);
    ack_delay = -1;
    for (int i = 0; i < BL - 1; i++) pulse_after(13, 1'b0);
    chk1("p3_fresh_wait", batch_req, 1'b0);
    pulse_after(13, 1'b0);
    chk1("p3_fresh_req", batch_req, 1'b1);
    ack_delay = 2;

    // 4: timeout after 255 silent cycles, then a late pulse and clr
    apply_reset();
    pulse_after(3, 1'b0);
    for (int i = 0; i < TMO - 1; i++) cycle(1'b0, 1'b0);
    chk1("p4_pre_timeout", timeout, 1'b0);
    cycle(1'b0, 1'b0);
    chk1("p4_timeout", timeout, 1'b1);
    pulse_after(10, 1'b0);
    chk8("p4_last", last_interval, 8'd255);
    chk1("p4_err", err_pulse, 1'b1);
    cycle(1'b0, 1'b1);
    chk1("p4_clr_timeout", timeout, 1'b0);
    chk8("p4_clr_errcnt", err_cnt, 8'd0);

    // 5: reset mid-batch discards everything
    ack_delay = -1;
    pulse_after(13, 1'b0);
    pulse_after(13, 1'b0);
    apply_reset();
    chk1("p5_req", batch_req, 1'b0);
    chk8("p5_last", last_interval, 8'd0);
    chk8("p5_errcnt", err_cnt, 8'd0);
    pulse_after(13, 1'b0);
    chk1("p5_first_noerr", err_pulse, 1'b0);
    for (int i = 0; i < BL - 2; i++) pulse_after(13, 1'b0);
    chk1("p5_wait", batch_req, 1'b0);
    pulse_after(13, 1'b0);
    chk1("p5_req_fresh", batch_req, 1'b1);

    // 6: clr coincident with an error, then saturation
    ack_delay = 2;
    apply_reset();
    pulse_after(3, 1'b0);
    for (int i = 0; i < 5; i++) pulse_after(5, 1'b0);
    chk8("p6_errcnt5", err_cnt, 8'd5);
    pulse_after(5, 1'b1);
    chk8("p6_clr_err", err_cnt, 8'd1);
    for (int i = 0; i < 260; i++) pulse_after($urandom_range(1, 11), 1'b0);
    chk8("p6_sat", err_cnt, 8'd255);
    pulse_after(20, 1'b0);
    chk1("p6_sat_pulse", err_pulse, 1'b1);
    chk8("p6_sat_hold", err_cnt, 8'd255);

    // Random traffic: spacing, clr and ack latency all vary
    for (int i = 0; i < 150; i++) begin
      ack_delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      pulse_after($urandom_range(1, 24), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) cycle(1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_done_monitor.md
Name: mode_done_monitor

Overview:
Downstream consumer of the single-cycle `done` pulse produced by the mode-sequencing FSM stage.
- Measures the cycle interval between successive `done` pulses and checks it against a legal window.
- Counts errors and flags timeouts.
- Groups every BATCH_LEN pulses into one batch, offered downstream over a req/ack handshake.

Parameters:
BATCH_LEN, 4, done pulses per batch (1..15)
PERIOD_MIN, 12, smallest legal interval in cycles
PERIOD_MAX, 14, largest legal interval in cycles
CW, 8, interval counter / last_interval width; TIMEOUT = 2^CW-1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
done_in  input  1  single-cycle done pulse from the mode FSM stage
batch_ack  input  1  downstream accepts the offered batch
clr  input  1  synchronous clear of err_cnt, overrun, timeout
batch_req  output  1  batch ready; held until batch_ack
last_interval  output  CW  most recent measured interval
err_pulse  output  1  one-cycle pulse on out-of-window interval
err_cnt  output  8  saturating error count
overrun  output  1  sticky: a full batch completed while the previous one was unacknowledged
timeout  output  1  sticky: no done_in for TIMEOUT cycles while armed

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: all outputs 0; internal state IDLE; pending=0; icnt=0; armed=0. Reset mid-batch discards everything.
- All outputs are registered. Response appears the cycle after the done_in/ack sampling edge.

Interval timer:
- Arms on the first done_in after reset.
- On each done_in: icnt<=0.
- Otherwise, while armed: icnt increments, saturating at TIMEOUT.
- Interval = icnt+1 at a done_in edge. Example: pulses at cycles t and t+13 give 13.
- At every done_in except the first after reset:
  - last_interval<=interval.
  - If interval<PERIOD_MIN or interval>PERIOD_MAX: err_pulse=1 for one cycle, and err_cnt increments (saturating at 255).
- icnt reaching TIMEOUT sets timeout. The next done_in is still measured: last_interval=TIMEOUT and err_pulse fires.
- clr same cycle as an error event: clear first, then count, so err_cnt=1. clr does not affect err_pulse or last_interval.

Batch FSM (IDLE, COLLECT, REQ):
- IDLE: on done_in, pending<=1 and go to COLLECT. If BATCH_LEN==1, go directly to REQ with pending<=0 and batch_req<=1.
- COLLECT: on done_in, pending++.
  - If the new value equals BATCH_LEN: pending<=0, batch_req<=1, go to REQ.
  - If pending is already BATCH_LEN on entry (backlog), go to REQ on the next edge without done_in.
- REQ: batch_req held high.
  - done_in increments pending.
  - When pending reaches BATCH_LEN while in REQ: overrun<=1, and pending saturates at BATCH_LEN (further dones dropped).
  - On batch_ack: batch_req<=0 and go to COLLECT. A done_in on the ack cycle counts before the ack is processed.
- batch_ack outside REQ is ignored.
- A backlogged batch therefore re-asserts batch_req after exactly one low cycle.

Decomposition:
- Shared package mode_pkg: batch FSM state encoding (IDLE=2'd0, COLLECT=2'd1, REQ=2'd2), default PERIOD_MIN/PERIOD_MAX/BATCH_LEN constants shared with the mode FSM stage's count limits.
- One natural sub-module: mode_interval_timer. It holds icnt, armed, the window compare, last_interval, err_pulse and timeout detect. Batch FSM, counters and sticky flags stay in the top level.

Test Plan:
1. done_in every 13 cycles, BATCH_LEN=4, ack 2 cycles after req -> batch_req rises the cycle after the 4th pulse and falls the cycle after ack; last_interval=13; err_cnt=0.
2. Pulses spaced 13, then 10, then 20 -> err_pulse twice (one cycle each), err_cnt=2, last_interval=20.
3. Hold batch_ack low through 4 further pulses -> overrun=1 after the 8th pulse. On ack, batch_req low one cycle then high again. The 9th+ pulses before ack are dropped.
4. One pulse then silence -> timeout=1 exactly 255 cycles after arming. A following pulse gives last_interval=255 and err_pulse. clr clears timeout and err_cnt.
5. rst_n low mid-batch (pending=2) -> all outputs 0. After release, the first pulse produces no err_pulse and the batch needs 4 fresh pulses.
6. clr coincident with an out-of-window pulse while err_cnt=5 -> err_cnt=1. Err_cnt at 255 plus a further error stays 255.
